// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the M-extension sequencer and pipeline hazard control.
// Holds funct3 codes, pipeline stage bit positions and the sequencer state type.
package mdu_ctrl_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int unsigned STG_PC      = 0;
  localparam int unsigned STG_IF_ID   = 1;
  localparam int unsigned STG_ID_EXE  = 2;
  localparam int unsigned STG_EXE_MEM = 3;
  localparam int unsigned STG_MEM_WB  = 4;
  localparam int unsigned NUM_STG     = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } md_state_e;

  // funct3[2] marks the divide/remainder group, funct3[0] the unsigned variants
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_div_op(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/mdu_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EXE writing a register that ID is about to read.
module hazard_detect
  import mdu_ctrl_pkg::*;
(
  input  logic       exe_is_load,
  input  logic [4:0] exe_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_re,
  input  logic       id_rs2_re,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_rs1_re && (id_rs1 == exe_rd);
    rs2_hit = id_rs2_re && (id_rs2 == exe_rd);
    hazard  = exe_is_load && (exe_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Pipeline stall/flush control and sequencer for the external iterative mul/div unit.
// Divide-by-zero and signed overflow are resolved locally without launching the unit.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MAX_LAT = 40,
  parameter int CNT_W   = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            md_req_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] md_rs1_i,
  input  logic [XLEN-1:0] md_rs2_i,
  input  logic            flush_all_i,
  input  logic            exe_branch_taken_i,
  input  logic            exe_is_load_i,
  input  logic [4:0]      exe_rd_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic            id_rs1_re_i,
  input  logic            id_rs2_re_i,
  output logic            unit_start_o,
  output logic [2:0]      unit_op_o,
  output logic [XLEN-1:0] unit_a_o,
  output logic [XLEN-1:0] unit_b_o,
  output logic            unit_cancel_o,
  input  logic            unit_ready_i,
  input  logic [XLEN-1:0] unit_result_i,
  output logic            md_valid_o,
  output logic [XLEN-1:0] md_result_o,
  output logic [4:0]      stall_o,
  output logic [4:0]      flush_o,
  output logic            timeout_o
);

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LAT - 1);

  md_state_e        state;
  logic [CNT_W-1:0] busy_cnt;
  logic             load_use;
  logic             div_by_zero;
  logic             div_overflow;
  logic             fast_hit;
  logic [XLEN-1:0]  fast_result;
  logic             mop_stall;

  hazard_detect u_hazard (
    .exe_is_load (exe_is_load_i),
    .exe_rd      (exe_rd_i),
    .id_rs1      (id_rs1_i),
    .id_rs2      (id_rs2_i),
    .id_rs1_re   (id_rs1_re_i),
    .id_rs2_re   (id_rs2_re_i),
    .hazard      (load_use)
  );

  always_comb begin
    div_by_zero  = is_div_op(md_op_i) && (md_rs2_i == '0);
    div_overflow = is_signed_div_op(md_op_i) && (md_rs1_i == INT_MIN) && (md_rs2_i == '1);
    fast_hit     = div_by_zero || div_overflow;
    // funct3[1] selects remainder within the divide group
    if (div_by_zero) begin
      fast_result = md_op_i[1] ? md_rs1_i : '1;
    end else begin
      fast_result = md_op_i[1] ? '0 : INT_MIN;
    end
  end

  always_comb begin
    mop_stall = (state == ST_BUSY) || ((state == ST_IDLE) && md_req_i);
    stall_o   = '0;
    flush_o   = '0;
    if (flush_all_i) begin
      flush_o[STG_IF_ID]   = 1'b1;
      flush_o[STG_ID_EXE]  = 1'b1;
      flush_o[STG_EXE_MEM] = 1'b1;
    end else if (exe_branch_taken_i) begin
      flush_o[STG_IF_ID]   = 1'b1;
      flush_o[STG_ID_EXE]  = 1'b1;
    end else if (mop_stall) begin
      stall_o[STG_PC]      = 1'b1;
      stall_o[STG_IF_ID]   = 1'b1;
      stall_o[STG_ID_EXE]  = 1'b1;
      flush_o[STG_EXE_MEM] = 1'b1;
    end else if (load_use) begin
      stall_o[STG_PC]      = 1'b1;
      stall_o[STG_IF_ID]   = 1'b1;
      flush_o[STG_ID_EXE]  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      busy_cnt      <= '0;
      unit_start_o  <= 1'b0;
      unit_cancel_o <= 1'b0;
      unit_op_o     <= '0;
      unit_a_o      <= '0;
      unit_b_o      <= '0;
      md_valid_o    <= 1'b0;
      md_result_o   <= '0;
      timeout_o     <= 1'b0;
    end else begin
      unit_start_o  <= 1'b0;
      unit_cancel_o <= 1'b0;
      md_valid_o    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (md_req_i && !flush_all_i) begin
            if (fast_hit) begin
              md_result_o <= fast_result;
              md_valid_o  <= 1'b1;
              state       <= ST_DONE;
            end else begin
              unit_op_o    <= md_op_i;
              unit_a_o     <= md_rs1_i;
              unit_b_o     <= md_rs2_i;
              unit_start_o <= 1'b1;
              busy_cnt     <= '0;
              state        <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (flush_all_i) begin
            unit_cancel_o <= 1'b1;
            state         <= ST_IDLE;
          end else if (unit_ready_i) begin
            md_result_o <= unit_result_i;
            md_valid_o  <= 1'b1;
            state       <= ST_DONE;
          end else if (busy_cnt == CNT_LAST) begin
            timeout_o     <= 1'b1;
            unit_cancel_o <= 1'b1;
            md_result_o   <= '0;
            md_valid_o    <= 1'b1;
            state         <= ST_DONE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: sequencing, fast-path divide results, timeout and hazard priority.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            md_req_i;
  logic [2:0]      md_op_i;
  logic [XLEN-1:0] md_rs1_i;
  logic [XLEN-1:0] md_rs2_i;
  logic            flush_all_i;
  logic            exe_branch_taken_i;
  logic            exe_is_load_i;
  logic [4:0]      exe_rd_i;
  logic [4:0]      id_rs1_i;
  logic [4:0]      id_rs2_i;
  logic            id_rs1_re_i;
  logic            id_rs2_re_i;
  logic            unit_start_o;
  logic [2:0]      unit_op_o;
  logic [XLEN-1:0] unit_a_o;
  logic [XLEN-1:0] unit_b_o;
  logic            unit_cancel_o;
  logic            unit_ready_i;
  logic [XLEN-1:0] unit_result_i;
  logic            md_valid_o;
  logic [XLEN-1:0] md_result_o;
  logic [4:0]      stall_o;
  logic [4:0]      flush_o;
  logic            timeout_o;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.XLEN(32), .MAX_LAT(40), .CNT_W(6)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .md_req_i           (md_req_i),
    .md_op_i            (md_op_i),
    .md_rs1_i           (md_rs1_i),
    .md_rs2_i           (md_rs2_i),
    .flush_all_i        (flush_all_i),
    .exe_branch_taken_i (exe_branch_taken_i),
    .exe_is_load_i      (exe_is_load_i),
    .exe_rd_i           (exe_rd_i),
    .id_rs1_i           (id_rs1_i),
    .id_rs2_i           (id_rs2_i),
    .id_rs1_re_i        (id_rs1_re_i),
    .id_rs2_re_i        (id_rs2_re_i),
    .unit_start_o       (unit_start_o),
    .unit_op_o          (unit_op_o),
    .unit_a_o           (unit_a_o),
    .unit_b_o           (unit_b_o),
    .unit_cancel_o      (unit_cancel_o),
    .unit_ready_i       (unit_ready_i),
    .unit_result_i      (unit_result_i),
    .md_valid_o         (md_valid_o),
    .md_result_o        (md_result_o),
    .stall_o            (stall_o),
    .flush_o            (flush_o),
    .timeout_o          (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    md_req_i           = 1'b0;
    md_op_i            = '0;
    md_rs1_i           = '0;
    md_rs2_i           = '0;
    flush_all_i        = 1'b0;
    exe_branch_taken_i = 1'b0;
    exe_is_load_i      = 1'b0;
    exe_rd_i           = '0;
    id_rs1_i           = '0;
    id_rs2_i           = '0;
    id_rs1_re_i        = 1'b0;
    id_rs2_re_i        = 1'b0;
    unit_ready_i       = 1'b0;
    unit_result_i      = '0;
  endtask

  task automatic test_reset(input string tag);
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({unit_start_o, unit_cancel_o, md_valid_o, timeout_o} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_flags: got %b expected 0000", tag,
               {unit_start_o, unit_cancel_o, md_valid_o, timeout_o});
    end
    checks++;
    if ({unit_op_o, unit_a_o, unit_b_o, md_result_o} !== '0) begin
      errors++;
      $display("FAIL %s_data: op=%h a=%h b=%h res=%h expected all 0", tag,
               unit_op_o, unit_a_o, unit_b_o, md_result_o);
    end
    checks++;
    if ({stall_o, flush_o} !== 10'b0) begin
      errors++;
      $display("FAIL %s_stall_flush: got %b/%b expected 00000/00000", tag, stall_o, flush_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_divu_normal();
    int stall_cyc = 0;
    int starts    = 0;
    @(negedge clk_i);
    md_req_i = 1'b1; md_op_i = F3_DIVU; md_rs1_i = 32'd100; md_rs2_i = 32'd7;
    #1;
    if (stall_o === 5'b00111) stall_cyc++;
    checks++;
    if (flush_o !== 5'b01000) begin
      errors++;
      $display("FAIL divu_accept_flush: got %b expected 01000", flush_o);
    end
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk_i);
      unit_ready_i = 1'b0;
      if (unit_start_o === 1'b1) starts++;
      if (stall_o === 5'b00111) stall_cyc++;
      if (k == 1) begin
        checks++;
        if ({unit_op_o, unit_a_o, unit_b_o} !== {F3_DIVU, 32'd100, 32'd7}) begin
          errors++;
          $display("FAIL divu_operands: op=%h a=%0d b=%0d expected 5/100/7",
                   unit_op_o, unit_a_o, unit_b_o);
        end
      end
      checks++;
      if (md_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL divu_busy_valid: cycle %0d got %b expected 0", k, md_valid_o);
      end
      if (k == 33) begin
        unit_ready_i  = 1'b1;
        unit_result_i = 32'd14;
      end
    end
    @(negedge clk_i);
    unit_ready_i = 1'b0; unit_result_i = '0;
    #1;
    checks++;
    if (starts != 1) begin
      errors++;
      $display("FAIL divu_start_count: got %0d expected 1", starts);
    end
    checks++;
    if (stall_cyc != 34) begin
      errors++;
      $display("FAIL divu_stall_cycles: got %0d expected 34", stall_cyc);
    end
    checks++;
    if ({md_valid_o, md_result_o} !== {1'b1, 32'd14}) begin
      errors++;
      $display("FAIL divu_result: valid=%b res=%0d expected 1/14", md_valid_o, md_result_o);
    end
    checks++;
    if (stall_o !== 5'b00000) begin
      errors++;
      $display("FAIL divu_done_stall: got %b expected 00000", stall_o);
    end
    @(negedge clk_i);
    checks++;
    if ({unit_start_o, md_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL divu_no_relaunch: start=%b valid=%b expected 0/0", unit_start_o, md_valid_o);
    end
    md_req_i = 1'b0;
  endtask

  task automatic do_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
    @(negedge clk_i);
    md_req_i = 1'b1; md_op_i = op; md_rs1_i = a; md_rs2_i = b;
    #1;
    checks++;
    if (stall_o !== 5'b00111) begin
      errors++;
      $display("FAIL %s_stall: got %b expected 00111", name, stall_o);
    end
    @(negedge clk_i);
    checks++;
    if ({unit_start_o, md_valid_o, md_result_o} !== {1'b0, 1'b1, exp}) begin
      errors++;
      $display("FAIL %s_result: start=%b valid=%b res=%h expected 0/1/%h",
               name, unit_start_o, md_valid_o, md_result_o, exp);
    end
    md_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    checks++;
    if ({md_valid_o, stall_o} !== 6'b0) begin
      errors++;
      $display("FAIL %s_idle: valid=%b stall=%b expected 0/00000", name, md_valid_o, stall_o);
    end
  endtask

  task automatic test_fast_path();
    do_fast(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    do_fast(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
    do_fast(F3_REM,  32'd5,         32'd0,         32'd5,         "rem_zero");
    do_fast(F3_DIVU, 32'd1234,      32'd0,         32'hFFFF_FFFF, "divu_zero");
    do_fast(F3_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, "div_zero");
    do_fast(F3_REMU, 32'd9,         32'd0,         32'd9,         "remu_zero");
  endtask

  task automatic test_flush_busy();
    @(negedge clk_i);
    md_req_i = 1'b1; md_op_i = F3_MUL; md_rs1_i = 32'd3; md_rs2_i = 32'd4;
    for (int k = 1; k <= 10; k++) @(negedge clk_i);
    flush_all_i = 1'b1;
    #1;
    checks++;
    if ({flush_o, stall_o} !== {5'b01110, 5'b00000}) begin
      errors++;
      $display("FAIL flush_busy_mux: flush=%b stall=%b expected 01110/00000", flush_o, stall_o);
    end
    @(negedge clk_i);
    flush_all_i = 1'b0;
    checks++;
    if ({unit_cancel_o, md_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL flush_busy_cancel: cancel=%b valid=%b expected 1/0", unit_cancel_o, md_valid_o);
    end
    md_req_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 5'b00000) begin
      errors++;
      $display("FAIL flush_busy_idle: stall=%b expected 00000", stall_o);
    end
    unit_ready_i = 1'b1; unit_result_i = 32'd12;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      unit_ready_i = 1'b0;
      checks++;
      if ({md_valid_o, unit_cancel_o, stall_o} !== 7'b0) begin
        errors++;
        $display("FAIL flush_late_ready: valid=%b cancel=%b stall=%b expected 0/0/00000",
                 md_valid_o, unit_cancel_o, stall_o);
      end
    end
  endtask

  task automatic test_timeout();
    @(negedge clk_i);
    md_req_i = 1'b1; md_op_i = F3_MULHU; md_rs1_i = 32'h0000_FFFF; md_rs2_i = 32'd2;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      checks++;
      if ({stall_o, timeout_o, md_valid_o} !== {5'b00111, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL timeout_busy: cycle %0d stall=%b to=%b valid=%b expected 00111/0/0",
                 k, stall_o, timeout_o, md_valid_o);
      end
    end
    @(negedge clk_i);
    checks++;
    if ({timeout_o, unit_cancel_o, md_valid_o, md_result_o} !== {3'b111, 32'd0}) begin
      errors++;
      $display("FAIL timeout_done: to=%b cancel=%b valid=%b res=%h expected 1/1/1/0",
               timeout_o, unit_cancel_o, md_valid_o, md_result_o);
    end
    md_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({timeout_o, unit_cancel_o, md_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_sticky: to=%b cancel=%b valid=%b expected 1/0/0",
               timeout_o, unit_cancel_o, md_valid_o);
    end
  endtask

  task automatic test_load_use();
    // is_load, rd, rs1, re1, rs2, re2, exp_stall, exp_flush
    logic [4:0] rd_v  [5] = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd5};
    logic [4:0] rs1_v [5] = '{5'd3, 5'd0, 5'd5, 5'd5, 5'd5};
    logic [4:0] rs2_v [5] = '{5'd5, 5'd0, 5'd7, 5'd7, 5'd5};
    logic       ld_v  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       re1_v [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       re2_v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] es_v  [5] = '{5'b00011, 5'b00000, 5'b00000, 5'b00011, 5'b00000};
    logic [4:0] ef_v  [5] = '{5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      exe_is_load_i = ld_v[i]; exe_rd_i = rd_v[i];
      id_rs1_i = rs1_v[i]; id_rs1_re_i = re1_v[i];
      id_rs2_i = rs2_v[i]; id_rs2_re_i = re2_v[i];
      #1;
      checks++;
      if ({stall_o, flush_o} !== {es_v[i], ef_v[i]}) begin
        errors++;
        $display("FAIL load_use_%0d: stall=%b flush=%b expected %b/%b",
                 i, stall_o, flush_o, es_v[i], ef_v[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    @(negedge clk_i);
    exe_is_load_i = 1'b1; exe_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_re_i = 1'b1;
    exe_branch_taken_i = 1'b1;
    #1;
    checks++;
    if ({stall_o, flush_o} !== {5'b00000, 5'b00110}) begin
      errors++;
      $display("FAIL prio_branch: stall=%b flush=%b expected 00000/00110", stall_o, flush_o);
    end
    flush_all_i = 1'b1;
    #1;
    checks++;
    if ({stall_o, flush_o} !== {5'b00000, 5'b01110}) begin
      errors++;
      $display("FAIL prio_flush_all: stall=%b flush=%b expected 00000/01110", stall_o, flush_o);
    end
    flush_all_i = 1'b0; exe_branch_taken_i = 1'b0;
    md_req_i = 1'b1; md_op_i = F3_DIVU; md_rs1_i = 32'd42; md_rs2_i = 32'd0;
    #1;
    checks++;
    if ({stall_o, flush_o} !== {5'b00111, 5'b01000}) begin
      errors++;
      $display("FAIL prio_mop_over_load: stall=%b flush=%b expected 00111/01000", stall_o, flush_o);
    end
    @(negedge clk_i);
    idle_inputs();
    checks++;
    if ({md_valid_o, md_result_o} !== {1'b1, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL prio_mop_result: valid=%b res=%h expected 1/ffffffff", md_valid_o, md_result_o);
    end
    @(negedge clk_i);
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset("reset");
    test_divu_normal();
    test_fast_path();
    test_flush_busy();
    test_timeout();
    test_load_use();
    test_priority();
    test_reset("rereset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
